video_stream_onchip_writer: RTL

Packs an 8-bit Avalon-ST pixel stream into 32-bit words and writes each video packet (frame) into the 4096 x 32 on-chip memory through that memory's single-port Avalon-MM slave. Sits directly upstream of the on-chip memory in the video system: it is the only writer on that port and produces all `address`, `byteenable`, `chipselect`, `write` and `writedata` traffic.

---
 rtl/video_stream_onchip_writer_if.sv | 40 ++++
 rtl/video_stream_onchip_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_onchip_writer_if.sv
// rtl/video_stream_onchip_writer_if.sv - pixel stream and on-chip memory bus interfaces
//
// video_stream_onchip_writer_st_if : 8-bit pixel stream with packet framing.
//   master = stream source (drives data/valid/sop/eop), slave = consumer (drives ready).
// video_stream_onchip_writer_mm_if : single-port memory write bus.
//   master = writer (drives address/byteenable/chipselect/write/writedata/clken),
//   slave = memory.

interface video_stream_onchip_writer_st_if;
    logic [7:0] sink_data;
    logic       sink_valid;
    logic       sink_startofpacket;
    logic       sink_endofpacket;
    logic       sink_ready;

    modport master (
        output sink_data, sink_valid, sink_startofpacket, sink_endofpacket,
        input  sink_ready
    );
    modport slave (
        input  sink_data, sink_valid, sink_startofpacket, sink_endofpacket,
        output sink_ready
    );
endinterface

interface video_stream_onchip_writer_mm_if;
    logic [11:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        clken;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken
    );
    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken
    );
endinterface

// File: rtl/video_stream_onchip_writer.sv
// rtl/video_stream_onchip_writer.sv - packs 8-bit pixel packets into 32-bit words in on-chip memory
//
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable           : capture enable, looked at only when a frame starts
//   clear_overflow   : synchronous clear of the sticky overflow flag
//   sink             : pixel stream in (never backpressured once out of reset)
//   mem              : memory write bus out, one registered write per committed word
//   frame_done       : one-cycle pulse when a captured frame ends
//   frame_words      : words written by the last completed frame
//   overflow         : sticky, a frame ran past DEPTH_WORDS

module video_stream_onchip_writer #(
    parameter int BASE_WORD   = 0,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              clear_overflow,
    video_stream_onchip_writer_st_if.slave    sink,
    video_stream_onchip_writer_mm_if.master   mem,
    output logic                              frame_done,
    output logic [12:0]                       frame_words,
    output logic                              overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PACK = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [12:0] BASE_W  = 13'(BASE_WORD);
    localparam logic [12:0] DEPTH_W = 13'(DEPTH_WORDS);

    logic [1:0]  state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [3:0]  pend_be_q, pend_be_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [12:0] word_cnt_q, word_cnt_d;
    logic        ready_q, ready_d;
    logic [11:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        frame_done_q, frame_done_d;
    logic [12:0] frame_words_q, frame_words_d;
    logic        overflow_q, overflow_d;

    logic        beat;
    logic        sop;
    logic        eop;
    logic [4:0]  lane_bit;
    logic [31:0] lane_data;
    logic [3:0]  lane_be;
    logic [12:0] commit_addr;

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        pend_be_d     = pend_be_q;
        pend_data_d   = pend_data_q;
        word_cnt_d    = word_cnt_q;
        ready_d       = 1'b1;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        write_d       = 1'b0;
        frame_done_d  = 1'b0;
        frame_words_d = frame_words_q;
        // Clear first so that a set later in this block takes priority.
        overflow_d    = clear_overflow ? 1'b0 : overflow_q;

        beat = sink.sink_valid & ready_q;
        sop  = sink.sink_startofpacket;
        eop  = sink.sink_endofpacket;

        // Pending word with the current beat merged into its lane.
        lane_bit  = {lane_q, 3'b000};
        lane_data = pend_data_q;
        lane_data[lane_bit +: 8] = sink.sink_data;
        lane_be   = pend_be_q | (4'b0001 << lane_q);

        commit_addr = BASE_W + word_cnt_q;

        if (beat) begin
            case (state_q)
                S_IDLE, S_PACK: begin
                    if (sop) begin
                        // A new frame always abandons any partial word.
                        lane_d      = 2'd0;
                        pend_be_d   = 4'b0000;
                        pend_data_d = 32'd0;
                        word_cnt_d  = 13'd0;
                        state_d     = S_IDLE;
                        if (enable) begin
                            if (eop) begin
                                // One-byte frame: committed at once at the base address.
                                addr_d        = BASE_W[11:0];
                                be_d          = 4'b0001;
                                wdata_d       = {24'd0, sink.sink_data};
                                write_d       = 1'b1;
                                word_cnt_d    = 13'd1;
                                frame_done_d  = 1'b1;
                                frame_words_d = 13'd1;
                            end else begin
                                pend_data_d = {24'd0, sink.sink_data};
                                pend_be_d   = 4'b0001;
                                lane_d      = 2'd1;
                                state_d     = S_PACK;
                            end
                        end
                    end else if (state_q == S_PACK) begin
                        if (lane_q == 2'd3 || eop) begin
                            lane_d      = 2'd0;
                            pend_be_d   = 4'b0000;
                            pend_data_d = 32'd0;
                            if (word_cnt_q == DEPTH_W) begin
                                overflow_d = 1'b1;
                                if (eop) begin
                                    // Overflow on the last beat: nothing left to drop.
                                    state_d       = S_IDLE;
                                    frame_done_d  = 1'b1;
                                    frame_words_d = DEPTH_W;
                                end else begin
                                    state_d = S_DROP;
                                end
                            end else begin
                                addr_d     = commit_addr[11:0];
                                be_d       = lane_be;
                                wdata_d    = lane_data;
                                write_d    = 1'b1;
                                word_cnt_d = word_cnt_q + 13'd1;
                                if (eop) begin
                                    state_d       = S_IDLE;
                                    frame_done_d  = 1'b1;
                                    frame_words_d = word_cnt_q + 13'd1;
                                end
                            end
                        end else begin
                            pend_data_d = lane_data;
                            pend_be_d   = lane_be;
                            lane_d      = lane_q + 2'd1;
                        end
                    end
                end
                S_DROP: begin
                    if (eop) begin
                        state_d       = S_IDLE;
                        frame_done_d  = 1'b1;
                        frame_words_d = DEPTH_W;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            lane_q        <= 2'd0;
            pend_be_q     <= 4'b0000;
            pend_data_q   <= 32'd0;
            word_cnt_q    <= 13'd0;
            ready_q       <= 1'b0;
            addr_q        <= 12'd0;
            be_q          <= 4'b0000;
            wdata_q       <= 32'd0;
            write_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_words_q <= 13'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            pend_be_q     <= pend_be_d;
            pend_data_q   <= pend_data_d;
            word_cnt_q    <= word_cnt_d;
            ready_q       <= ready_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            frame_done_q  <= frame_done_d;
            frame_words_q <= frame_words_d;
            overflow_q    <= overflow_d;
        end
    end

    assign sink.sink_ready = ready_q;
    assign mem.address     = addr_q;
    assign mem.byteenable  = be_q;
    assign mem.writedata   = wdata_q;
    assign mem.chipselect  = write_q;
    assign mem.write       = write_q;
    assign mem.clken       = 1'b1;
    assign frame_done      = frame_done_q;
    assign frame_words     = frame_words_q;
    assign overflow        = overflow_q;

endmodule
